// File: rtl/hdmi_i2c_cfg_seq_if.sv
// Request/done handshake between the config sequencer (master) and the I2C byte engine (slave).
interface hdmi_i2c_cfg_seq_if;
  logic       i2c_rqt;
  logic       cmd;
  logic [6:0] addr_dev;
  logic [7:0] addr_reg_H;
  logic [7:0] addr_reg_L;
  logic [7:0] data_wr_H;
  logic [7:0] data_wr_L;
  logic [7:0] data_rd;
  logic       data_rdy;
  logic       i2c_done;

  modport master (
    output i2c_rqt, cmd, addr_dev, addr_reg_H, addr_reg_L, data_wr_H, data_wr_L,
    input  data_rd, data_rdy, i2c_done
  );

  modport slave (
    input  i2c_rqt, cmd, addr_dev, addr_reg_H, addr_reg_L, data_wr_H, data_wr_L,
    output data_rd, data_rdy, i2c_done
  );
endinterface

// File: rtl/hdmi_i2c_cfg_seq.sv
// Table-driven HDMI transmitter configuration sequencer: walks a ROM of write/delay/verify/end
// entries, drives the I2C byte engine, retries failed attempts and reports done or error.
module hdmi_i2c_cfg_seq #(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         TBL_AW      = 8,
  parameter int         PWRUP_CYC   = 1000,
  parameter int         TIMEOUT_CYC = 65535,
  parameter int         MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [39:0]       tbl_data,
  hdmi_i2c_cfg_seq_if.master i2c,
  output logic              busy,
  output logic              config_done,
  output logic              config_err,
  output logic [TBL_AW-1:0] err_index
);

  localparam int PWR_W = (PWRUP_CYC   > 1) ? $clog2(PWRUP_CYC + 1)   : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_DLY = 2'b01;
  localparam logic [1:0] OP_VER = 2'b10;

  typedef enum logic [3:0] {
    S_PWRUP, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_CHECK, S_DLY, S_DONE, S_ERR
  } state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] reg_addr;
    logic [15:0] operand;
  } entry_t;

  state_e            state_q, state_d;
  entry_t            ent_q, ent_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [TBL_AW-1:0] eidx_q, eidx_d;
  logic [PWR_W-1:0]  pwr_q, pwr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [19:0]       dly_q, dly_d;
  logic [3:0]        retry_q, retry_d;
  logic              pass_q, pass_d;
  logic              rqt_q, rqt_d;
  logic              cmd_q, cmd_d;
  logic [15:0]       areg_q, areg_d;
  logic [15:0]       wdat_q, wdat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              advance;
  logic [7:0]        vmask;

  assign vmask = ent_q.operand[15:8];

  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    idx_d   = idx_q;
    eidx_d  = eidx_q;
    pwr_d   = pwr_q;
    tmo_d   = tmo_q;
    dly_d   = dly_q;
    retry_d = retry_q;
    pass_d  = pass_q;
    rqt_d   = rqt_q;
    cmd_d   = cmd_q;
    areg_d  = areg_q;
    wdat_d  = wdat_q;
    advance = 1'b0;

    case (state_q)
      S_PWRUP: begin
        if (pwr_q == PWR_W'(PWRUP_CYC - 1)) begin
          pwr_d   = '0;
          state_d = S_FETCH;
        end else begin
          pwr_d = pwr_q + 1'b1;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ent_d   = '{op: tbl_data[39:38], reg_addr: tbl_data[31:16], operand: tbl_data[15:0]};
        retry_d = '0;
        case (tbl_data[39:38])
          OP_WR, OP_VER: state_d = S_ISSUE;
          OP_DLY: begin
            if (tbl_data[15:0] == 16'h0) begin
              advance = 1'b1;
            end else begin
              dly_d   = {tbl_data[15:0], 4'h0};
              state_d = S_DLY;
            end
          end
          default: state_d = S_DONE;
        endcase
      end
      S_ISSUE: begin
        rqt_d   = 1'b1;
        cmd_d   = (ent_q.op == OP_VER);
        areg_d  = ent_q.reg_addr;
        wdat_d  = (ent_q.op == OP_WR) ? ent_q.operand : 16'h0;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done is checked before the timeout so a coincident done still counts as success
        if (i2c.i2c_done) begin
          rqt_d   = 1'b0;
          pass_d  = (ent_q.op == OP_WR) ||
                    (i2c.data_rdy && ((i2c.data_rd & vmask) == (ent_q.operand[7:0] & vmask)));
          state_d = S_CHECK;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rqt_d   = 1'b0;
          pass_d  = 1'b0;
          state_d = S_CHECK;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        // CHECK itself is the low-rqt gap before a retry is reissued
        if (pass_q) begin
          advance = 1'b1;
        end else if (retry_q < 4'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          eidx_d  = idx_q;
          state_d = S_ERR;
        end
      end
      S_DLY: begin
        if (dly_q <= 20'd1) advance = 1'b1;
        else                dly_d   = dly_q - 1'b1;
      end
      S_DONE, S_ERR: begin
        if (start) begin
          idx_d   = '0;
          eidx_d  = '0;
          pwr_d   = '0;
          state_d = S_PWRUP;
        end
      end
      default: state_d = S_ERR;
    endcase

    // running off the end of the table without an END entry is an error
    if (advance) begin
      retry_d = '0;
      if (idx_q == {TBL_AW{1'b1}}) begin
        eidx_d  = idx_q;
        state_d = S_ERR;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    busy_d = !(state_d == S_DONE || state_d == S_ERR);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PWRUP;
      ent_q   <= '0;
      idx_q   <= '0;
      eidx_q  <= '0;
      pwr_q   <= '0;
      tmo_q   <= '0;
      dly_q   <= '0;
      retry_q <= '0;
      pass_q  <= 1'b0;
      rqt_q   <= 1'b0;
      cmd_q   <= 1'b0;
      areg_q  <= '0;
      wdat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      idx_q   <= idx_d;
      eidx_q  <= eidx_d;
      pwr_q   <= pwr_d;
      tmo_q   <= tmo_d;
      dly_q   <= dly_d;
      retry_q <= retry_d;
      pass_q  <= pass_d;
      rqt_q   <= rqt_d;
      cmd_q   <= cmd_d;
      areg_q  <= areg_d;
      wdat_q  <= wdat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tbl_addr       = idx_q;
  assign i2c.i2c_rqt    = rqt_q;
  assign i2c.cmd        = cmd_q;
  assign i2c.addr_dev   = DEV_ADDR;
  assign i2c.addr_reg_H = areg_q[15:8];
  assign i2c.addr_reg_L = areg_q[7:0];
  assign i2c.data_wr_H  = wdat_q[15:8];
  assign i2c.data_wr_L  = wdat_q[7:0];
  assign busy           = busy_q;
  assign config_done    = done_q;
  assign config_err     = err_q;
  assign err_index      = eidx_q;

endmodule

// File: tb/tb_hdmi_i2c_cfg_seq.sv
// Directed bench for hdmi_i2c_cfg_seq: ROM model, scripted I2C engine, immediate-assert checks.
module tb_hdmi_i2c_cfg_seq;
  localparam int TBL_AW = 4, PWRUP_CYC = 10, TIMEOUT_CYC = 100, MAX_RETRY = 3;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [TBL_AW-1:0] tbl_addr, err_index;
  logic [39:0]       tbl_data;
  logic              busy, config_done, config_err;

  hdmi_i2c_cfg_seq_if i2c ();

  hdmi_i2c_cfg_seq #(.DEV_ADDR(7'h39), .TBL_AW(TBL_AW), .PWRUP_CYC(PWRUP_CYC),
                     .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .i2c(i2c), .busy(busy), .config_done(config_done), .config_err(config_err),
    .err_index(err_index));

  always #5 clk = ~clk;

  logic [39:0] rom [16];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // scripted engine: counts/logs every rqt rise, answers done after eng_lat cycles
  int          rqt_cnt = 0, eng_cyc = 0, eng_lat = 20;
  logic        eng_hang = 1'b0, eng_clr = 1'b0;
  logic [7:0]  rd_tbl   [32];
  logic [15:0] log_areg [32];
  logic [15:0] log_wdat [32];
  logic        log_cmd  [32];

  always @(posedge clk) begin
    i2c.i2c_done <= 1'b0;
    i2c.data_rdy <= 1'b0;
    if (eng_clr) begin
      rqt_cnt <= 0;
      eng_cyc <= 0;
    end else if (!i2c.i2c_rqt) begin
      eng_cyc <= 0;
    end else begin
      if (eng_cyc == 0) begin
        log_areg[rqt_cnt[4:0]] <= {i2c.addr_reg_H, i2c.addr_reg_L};
        log_wdat[rqt_cnt[4:0]] <= {i2c.data_wr_H, i2c.data_wr_L};
        log_cmd[rqt_cnt[4:0]]  <= i2c.cmd;
        rqt_cnt <= rqt_cnt + 1;
      end
      eng_cyc <= eng_cyc + 1;
      if (!eng_hang && eng_cyc == eng_lat - 1) begin
        i2c.i2c_done <= 1'b1;
        i2c.data_rdy <= i2c.cmd;
        i2c.data_rd  <= rd_tbl[5'(rqt_cnt - 1)];
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] ent(input logic [1:0] op, input logic [15:0] ra,
                                      input logic [15:0] opnd);
    return {op, 6'h0, ra, opnd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(config_done || config_err) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clr_counts();
    eng_clr = 1'b1;
    tick();
    eng_clr = 1'b0;
  endtask

  task automatic fill_end();
    for (int i = 0; i < 16; i++) rom[i] = ent(2'b11, 16'h0, 16'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) rd_tbl[i] = 8'h00;
    fill_end();
    rom[0] = ent(2'b00, 16'h0041, 16'h0010);
    rom[1] = ent(2'b00, 16'h0098, 16'h0003);

    // reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(config_done), 32'd0);
    chk("rst_err", 32'(config_err), 32'd0);
    chk("rst_rqt", 32'(i2c.i2c_rqt), 32'd0);
    chk("rst_addr_dev", 32'(i2c.addr_dev), 32'h39);
    rst = 1'b0;
    tick();
    chk("pwrup_busy", 32'(busy), 32'd1);

    // 1: two writes then END, engine latency 20
    wait_end("t1_end", 2000);
    chk("t1_done", 32'(config_done), 32'd1);
    chk("t1_err", 32'(config_err), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_nreq", 32'(rqt_cnt), 32'd2);
    chk("t1_areg0", 32'(log_areg[0]), 32'h0041);
    chk("t1_wdat0", 32'(log_wdat[0]), 32'h0010);
    chk("t1_cmd0", 32'(log_cmd[0]), 32'd0);
    chk("t1_areg1", 32'(log_areg[1]), 32'h0098);
    chk("t1_wdat1", 32'(log_wdat[1]), 32'h0003);

    // 2: verify passes on 0xA5, then fails on 0x55 for 1+MAX_RETRY attempts
    fill_end();
    rom[0] = ent(2'b10, 16'h0042, 16'hF0A0);
    rom[1] = ent(2'b10, 16'h0042, 16'hF0A0);
    rd_tbl[0] = 8'hA5;
    for (int i = 1; i < 5; i++) rd_tbl[i] = 8'h55;
    eng_lat = 6;
    clr_counts();
    pulse_start();
    chk("t2_done_cleared", 32'(config_done), 32'd0);
    wait_end("t2_end", 2000);
    chk("t2_err", 32'(config_err), 32'd1);
    chk("t2_done", 32'(config_done), 32'd0);
    chk("t2_nreq", 32'(rqt_cnt), 32'd5);
    chk("t2_eidx", 32'(err_index), 32'd1);
    chk("t2_cmd0", 32'(log_cmd[0]), 32'd1);
    chk("t2_areg4", 32'(log_areg[4]), 32'h0042);

    // 3: engine hangs -> each attempt times out after TIMEOUT_CYC cycles
    fill_end();
    rom[0] = ent(2'b00, 16'h0012, 16'h0034);
    eng_hang = 1'b1;
    clr_counts();
    pulse_start();
    chk("t3_eidx_cleared", 32'(err_index), 32'd0);
    n = 0;
    while (!i2c.i2c_rqt && n < 200) begin tick(); n++; end
    chk("t3_rqt_rise", 32'(n < 200), 32'd1);
    n = 0;
    while (i2c.i2c_rqt && n < 300) begin tick(); n++; end
    chk("t3_rqt_width", 32'(n), 32'd100);
    wait_end("t3_end", 2000);
    chk("t3_err", 32'(config_err), 32'd1);
    chk("t3_nreq", 32'(rqt_cnt), 32'd4);
    chk("t3_eidx", 32'(err_index), 32'd0);
    eng_hang = 1'b0;

    // done sampled on the timeout-expiry cycle counts as success
    eng_lat = 99;
    clr_counts();
    pulse_start();
    wait_end("tmo_edge_end", 2000);
    chk("tmo_edge_done", 32'(config_done), 32'd1);
    chk("tmo_edge_nreq", 32'(rqt_cnt), 32'd1);
    // one cycle later the attempt has already timed out; the late done is ignored
    eng_lat = 100;
    clr_counts();
    pulse_start();
    wait_end("tmo_late_end", 3000);
    chk("tmo_late_err", 32'(config_err), 32'd1);
    chk("tmo_late_nreq", 32'(rqt_cnt), 32'd4);

    // 4: DELAY 5 between writes. After the first rqt falls: 3 cycles to fetch/decode the
    // delay entry, 80 delay cycles, then the 3-cycle fetch-to-rqt latency = 86.
    fill_end();
    rom[0] = ent(2'b00, 16'h0001, 16'h00AA);
    rom[1] = ent(2'b01, 16'h0000, 16'h0005);
    rom[2] = ent(2'b00, 16'h0002, 16'h00BB);
    eng_lat = 5;
    clr_counts();
    pulse_start();
    n = 0;
    while (!i2c.i2c_rqt && n < 200) begin tick(); n++; end
    n = 0;
    while (i2c.i2c_rqt && n < 200) begin tick(); n++; end
    n = 0;
    while (!i2c.i2c_rqt && n < 300) begin tick(); n++; end
    chk("t4_delay_gap", 32'(n), 32'd86);
    wait_end("t4_end", 2000);
    chk("t4_done", 32'(config_done), 32'd1);
    chk("t4_nreq", 32'(rqt_cnt), 32'd2);
    chk("t4_areg1", 32'(log_areg[1]), 32'h0002);
    chk("t4_wdat1", 32'(log_wdat[1]), 32'h00BB);

    // 5: reset in WAIT, start ignored in PWRUP, start after DONE reruns from index 0
    fill_end();
    rom[0] = ent(2'b00, 16'h0041, 16'h0010);
    rom[1] = ent(2'b00, 16'h0098, 16'h0003);
    eng_lat = 20;
    pulse_start();
    n = 0;
    while (!i2c.i2c_rqt && n < 200) begin tick(); n++; end
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("t5_rqt_drop", 32'(i2c.i2c_rqt), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    clr_counts();
    rst = 1'b0;
    n = 0;
    while (!i2c.i2c_rqt && n < 100) begin
      start = (n == 4);
      tick();
      n++;
    end
    start = 1'b0;
    chk("t5_pwrup_to_rqt", 32'(n), 32'd13);
    wait_end("t5_end", 2000);
    chk("t5_done", 32'(config_done), 32'd1);
    chk("t5_nreq", 32'(rqt_cnt), 32'd2);
    clr_counts();
    pulse_start();
    wait_end("t5_rerun_end", 2000);
    chk("t5_rerun_done", 32'(config_done), 32'd1);
    chk("t5_rerun_nreq", 32'(rqt_cnt), 32'd2);
    chk("t5_rerun_areg0", 32'(log_areg[0]), 32'h0041);

    // index overflow: 16 writes with no END entry
    for (int i = 0; i < 16; i++) rom[i] = ent(2'b00, 16'h0100 + 16'(i), 16'(i));
    eng_lat = 3;
    clr_counts();
    pulse_start();
    wait_end("ovf_end", 3000);
    chk("ovf_err", 32'(config_err), 32'd1);
    chk("ovf_done", 32'(config_done), 32'd0);
    chk("ovf_eidx", 32'(err_index), 32'd15);
    chk("ovf_nreq", 32'(rqt_cnt), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
